// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Forwarding-select codes and shared types for the hazard unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] NO_FORWARD  = 2'b00;
  localparam logic [1:0] WB_FORWARD  = 2'b01;
  localparam logic [1:0] MEM_FORWARD = 2'b10;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic stall_w;
    logic flush_d;
    logic flush_e;
  } hazard_ctrl_t;

  // Written with & so that a deasserted write enable masks X on the indices.
  function automatic logic reg_match(input reg_idx_t rs, input reg_idx_t rd, input logic we);
    return we & (rs != '0) & (rs == rd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/forward_select.sv
// ============================================================================
// Module      : forward_select
// Description : Picks the Execute-stage operand source for one source register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] Rs,
  input  logic [4:0] RdM,
  input  logic       RegWriteM,
  input  logic [4:0] RdW,
  input  logic       RegWriteW,
  output logic [1:0] Forward
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = reg_match(Rs, RdM, RegWriteM);
  assign w_wb_hit  = reg_match(Rs, RdW, RegWriteW);

  // The younger Memory result shadows the Writeback one.
  always_comb begin
    Forward = ({2{w_mem_hit}} & MEM_FORWARD)
            | ({2{~w_mem_hit & w_wb_hit}} & WB_FORWARD);
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Stall, flush and forwarding control for the 5-stage pipeline.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_unit
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       InstrMissF,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic       ResultSrcEb2,
  input  logic       PCSrcb1,
  input  logic [4:0] RdM,
  input  logic       RegWriteM,
  input  logic [4:0] RdW,
  input  logic       RegWriteW,
  input  logic [1:0] PCSrcReg,
  input  logic       InstrCacheRepActive,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  logic         w_load_stall;
  logic         w_redirect_pending;
  hazard_ctrl_t w_ctrl;

  // Pure decode of the current cycle; these inputs exist only for interface symmetry.
  logic w_unused;
  assign w_unused = &{1'b0, clk, reset, InstrCacheRepActive, PCSrcReg[0]};

  forward_select u_forward_a (
    .Rs        (Rs1E),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardAE)
  );

  forward_select u_forward_b (
    .Rs        (Rs2E),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardBE)
  );

  assign w_load_stall       = ResultSrcEb2 & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));
  assign w_redirect_pending = PCSrcReg[1];

  // A latched redirect frees Fetch; a fresh mispredict during a miss waits to be latched.
  always_comb begin
    w_ctrl         = '0;
    w_ctrl.stall_f = w_load_stall | (InstrMissF & ~w_redirect_pending);
    w_ctrl.stall_d = w_load_stall | InstrMissF;
    w_ctrl.stall_e = InstrMissF;
    w_ctrl.stall_m = InstrMissF;
    w_ctrl.stall_w = InstrMissF;
    w_ctrl.flush_d = PCSrcb1 | w_redirect_pending;
    w_ctrl.flush_e = (~InstrMissF & (w_load_stall | PCSrcb1)) | w_redirect_pending;
  end

  assign StallF = w_ctrl.stall_f;
  assign StallD = w_ctrl.stall_d;
  assign StallE = w_ctrl.stall_e;
  assign StallM = w_ctrl.stall_m;
  assign StallW = w_ctrl.stall_w;
  assign FlushD = w_ctrl.flush_d;
  assign FlushE = w_ctrl.flush_e;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit with a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic       InstrMissF;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcEb2, PCSrcb1, RegWriteM, RegWriteW, InstrCacheRepActive;
  logic [1:0] PCSrcReg;
  logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;

  int n_checks = 0;
  int n_fail   = 0;

  // {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,ForwardAE,ForwardBE}
  logic [10:0] obs;
  assign obs = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE, ForwardBE};

  hazard_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .InstrMissF          (InstrMissF),
    .Rs1D                (Rs1D),
    .Rs2D                (Rs2D),
    .Rs1E                (Rs1E),
    .Rs2E                (Rs2E),
    .RdE                 (RdE),
    .ResultSrcEb2        (ResultSrcEb2),
    .PCSrcb1             (PCSrcb1),
    .RdM                 (RdM),
    .RegWriteM           (RegWriteM),
    .RdW                 (RdW),
    .RegWriteW           (RegWriteW),
    .PCSrcReg            (PCSrcReg),
    .InstrCacheRepActive (InstrCacheRepActive),
    .StallF              (StallF),
    .StallD              (StallD),
    .StallE              (StallE),
    .StallM              (StallM),
    .StallW              (StallW),
    .FlushD              (FlushD),
    .FlushE              (FlushE),
    .ForwardAE           (ForwardAE),
    .ForwardBE           (ForwardBE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Producers searched youngest first; the first live writer of rs supplies it.
  function automatic logic [1:0] ref_forward(input logic [4:0] rs);
    logic [4:0] dst [2];
    logic       wen [2];
    logic [1:0] code [2];
    dst  = '{RdM, RdW};
    wen  = '{RegWriteM, RegWriteW};
    code = '{2'd2, 2'd1};
    if (rs == 5'd0) return 2'd0;
    for (int i = 0; i < 2; i++)
      if (wen[i] && dst[i] == rs) return code[i];
    return 2'd0;
  endfunction

  function automatic logic [10:0] ref_model();
    bit load_use, miss, fresh_redirect, pending;
    bit [4:0] stalls;
    bit fd, fe;
    load_use       = ResultSrcEb2 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    miss           = InstrMissF;
    fresh_redirect = PCSrcb1;
    pending        = PCSrcReg[1];
    // A miss freezes the whole pipe; a load-use bubble freezes only F and D.
    stalls = miss ? 5'b11111 : 5'b00000;
    if (load_use) stalls[4:3] = 2'b11;
    if (miss && pending) stalls[4] = load_use;
    fd = fresh_redirect || pending;
    fe = pending || (!miss && (load_use || fresh_redirect));
    return {stalls, fd, fe, ref_forward(Rs1E), ref_forward(Rs2E)};
  endfunction

  task automatic set_idle();
    InstrMissF = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    ResultSrcEb2 = 0; PCSrcb1 = 0; RdM = 0; RegWriteM = 0; RdW = 0;
    RegWriteW = 0; PCSrcReg = 0; InstrCacheRepActive = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp_v;
    reset = 1; set_idle(); step(); #1;
    exp_v = 11'b00000_00_00_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, exp_v); end
    InstrMissF = 1; #1;
    exp_v = 11'b11111_00_00_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_miss: got %b want %b", obs, exp_v); end
    step(); reset = 0; set_idle();
  endtask

  task automatic test_forwarding();
    logic [10:0] exp_v;
    step(); set_idle();
    RegWriteM = 1; RdM = 5; Rs1E = 5; Rs2E = 5; #1;
    exp_v = 11'b00000_00_10_10;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fwd_mem: got %b want %b", obs, exp_v); end
    RegWriteM = 0; RdW = 5; RegWriteW = 1; #1;
    exp_v = 11'b00000_00_01_01;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fwd_wb: got %b want %b", obs, exp_v); end
    Rs1E = 0; RdM = 0; RegWriteM = 1; RdW = 0; #1;
    exp_v = 11'b00000_00_00_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fwd_x0: got %b want %b", obs, exp_v); end
    Rs1E = 7; Rs2E = 3; RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; #1;
    exp_v = 11'b00000_00_10_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fwd_priority: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_load_use();
    logic [10:0] exp_v;
    step(); set_idle();
    ResultSrcEb2 = 1; RdE = 1; Rs1D = 1; #1;
    exp_v = 11'b11000_01_00_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL load_use_rs1: got %b want %b", obs, exp_v); end
    RdE = 2; Rs1D = 0; Rs2D = 2; #1;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL load_use_rs2: got %b want %b", obs, exp_v); end
    RdE = 1; Rs1D = 0; Rs2D = 0; #1;
    exp_v = 11'b00000_00_00_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL load_no_use: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_cache_miss();
    logic [10:0] exp_v;
    step(); set_idle();
    InstrMissF = 1; #1;
    exp_v = 11'b11111_00_00_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cache_miss: got %b want %b", obs, exp_v); end
    ResultSrcEb2 = 1; RdE = 4; Rs1D = 4; #1;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL miss_load_use: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_mispredict_hit();
    logic [10:0] exp_v;
    step(); set_idle();
    PCSrcb1 = 1; #1;
    exp_v = 11'b00000_11_00_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL hit_mispredict: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_miss_mispredict_seq();
    logic [10:0] exp_v;
    step(); set_idle();
    InstrMissF = 1; PCSrcb1 = 1; PCSrcReg = 2'b00; #1;
    exp_v = 11'b11111_10_00_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL seq_cycle1: got %b want %b", obs, exp_v); end
    step();
    InstrMissF = 1; PCSrcb1 = 0; PCSrcReg = 2'b11; #1;
    exp_v = 11'b01111_11_00_00;
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL seq_cycle2: got %b want %b", obs, exp_v); end
    for (int m = 0; m < 2; m++) begin
      step();
      InstrMissF = m[0]; PCSrcb1 = 0; PCSrcReg = 2'b00; #1;
      exp_v = {{5{m[0]}}, 6'b00_00_00};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL seq_cycle3_m%0d: got %b want %b", m, obs, exp_v); end
    end
  endtask

  task automatic test_miss_predicted();
    logic [10:0] exp_v;
    exp_v = 11'b11111_00_00_00;
    for (int r = 0; r < 2; r++) begin
      step(); set_idle();
      InstrMissF = 1; PCSrcb1 = 0; PCSrcReg = 0; InstrCacheRepActive = r[0]; #1;
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL miss_predicted_rep%0d: got %b want %b", r, obs, exp_v); end
    end
  endtask

  task automatic test_random();
    logic [10:0] exp_v;
    for (int i = 0; i < 300; i++) begin
      step();
      // Narrow register range so matches are frequent.
      InstrMissF = 1'($urandom_range(0, 1));
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      ResultSrcEb2 = 1'($urandom); PCSrcb1 = 1'($urandom);
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      PCSrcReg = 2'($urandom); InstrCacheRepActive = 1'($urandom);
      #1;
      exp_v = ref_model();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random_%0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    reset = 0;
    set_idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_cache_miss();
    test_mispredict_hit();
    test_miss_mispredict_seq();
    test_miss_predicted();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
